// File: rtl/parking_space_allocator.sv
// parking_space_allocator: stateful bay allocator granting, releasing and counting parking bays
// Ports: clk, reset (sync, active-high); entry_req -> entry_ack/entry_reject/entry_space;
//        exit_req + exit_space -> exit_ack/exit_err; occupancy, free_count, full, empty status.
module parking_space_allocator #(
    parameter int N_SPACES = 8,
    parameter int ID_W     = $clog2(N_SPACES),
    parameter int MODE     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                entry_req,
    input  logic                exit_req,
    input  logic [ID_W-1:0]     exit_space,
    output logic                entry_ack,
    output logic                entry_reject,
    output logic [ID_W-1:0]     entry_space,
    output logic                exit_ack,
    output logic                exit_err,
    output logic [N_SPACES-1:0] occupancy,
    output logic [ID_W:0]       free_count,
    output logic                full,
    output logic                empty
);
    logic [ID_W-1:0]       ptr, ptr_n, sel;
    logic [N_SPACES-1:0]   occ_n;
    logic [(1<<ID_W)-1:0]  occ_pad;
    logic [ID_W:0]         fc_n;
    logic                  grant, exit_ok;
    int                    j;
    // Bays beyond N_SPACES read as free, so out-of-range exits fall out as errors.
    always_comb begin
        occ_pad = '0;
        occ_pad[N_SPACES-1:0] = occupancy;
    end
    // Scan downward so the first free bay at or after the search base wins.
    always_comb begin
        sel = '0;
        j = 0;
        for (int i = N_SPACES - 1; i >= 0; i--) begin
            j = (MODE == 1 ? int'(ptr) : 0) + i;
            j = j >= N_SPACES ? j - N_SPACES : j;
            if (!occ_pad[ID_W'(j)]) sel = ID_W'(j);
        end
    end
    // The granted bay is always free and the released bay always occupied, so the masks never collide.
    always_comb begin
        grant   = entry_req && free_count != '0;
        exit_ok = exit_req && occ_pad[exit_space];
        occ_n   = (occupancy | (grant ? N_SPACES'(1) << sel : '0)) &
                  ~(exit_ok ? N_SPACES'(1) << exit_space : '0);
        fc_n    = free_count + (ID_W+1)'(exit_ok) - (ID_W+1)'(grant);
        ptr_n   = grant ? (sel == ID_W'(N_SPACES - 1) ? '0 : sel + ID_W'(1)) : ptr;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy    <= '0;
            free_count   <= (ID_W+1)'(N_SPACES);
            full         <= 1'b0;
            empty        <= 1'b1;
            entry_ack    <= 1'b0;
            entry_reject <= 1'b0;
            entry_space  <= '0;
            exit_ack     <= 1'b0;
            exit_err     <= 1'b0;
            ptr          <= '0;
        end else begin
            occupancy    <= occ_n;
            free_count   <= fc_n;
            full         <= fc_n == '0;
            empty        <= fc_n == (ID_W+1)'(N_SPACES);
            entry_ack    <= grant;
            entry_reject <= entry_req && !grant;
            entry_space  <= grant ? sel : '0;
            exit_ack     <= exit_ok;
            exit_err     <= exit_req && !exit_ok;
            ptr          <= ptr_n;
        end
    end
endmodule

// File: doc/parking_space_allocator.md
Name: parking_space_allocator

Overview:
Sequential, parametrised parking-space manager. Keeps an occupancy register for N_SPACES bays and grants a free bay on each entry request. It releases a bay on each exit request and reports free count and full/empty status. It sits between the gate sensors/controller and the display logic, and replaces the purely combinational first-free-bay lookup with a stateful allocator.

Parameters:
N_SPACES, 8, number of parking bays (2..256)
ID_W, $clog2(N_SPACES), width of a bay index
MODE, 0, allocation policy: 0 = lowest-index free bay; 1 = next-fit (round-robin search starting after the last granted bay)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
entry_req  input  1  car at entry gate requests a bay (sampled each rising edge)
exit_req  input  1  car leaving (sampled each rising edge)
exit_space  input  ID_W  bay index being vacated, valid with exit_req
entry_ack  output  1  one-cycle pulse: bay granted
entry_reject  output  1  one-cycle pulse: request refused, lot full
entry_space  output  ID_W  granted bay index, valid while entry_ack=1, else 0
exit_ack  output  1  one-cycle pulse: bay released
exit_err  output  1  one-cycle pulse: exit_space out of range or bay already free
occupancy  output  N_SPACES  bit i = 1 when bay i is occupied
free_count  output  ID_W+1  number of free bays
full  output  1  free_count == 0
empty  output  1  free_count == N_SPACES

Behaviour:
- Reset (synchronous; overrides requests in the same cycle): occupancy=0, free_count=N_SPACES, full=0, empty=1, entry_ack=entry_reject=exit_ack=exit_err=0, entry_space=0, next-fit pointer=0.
- All outputs are registered. A request sampled at edge k produces its response on the outputs after edge k, for exactly one cycle. Latency is 1.
- A request held high for several cycles is treated as one new request per cycle. Each cycle may grant one bay.
- Entry with at least one free bay: select a bay from the occupancy value before this edge.
  - MODE 0: lowest-index free bay.
  - MODE 1: first free bay scanning from pointer, pointer+1, …, wrapping modulo N_SPACES. The pointer is updated to (granted+1) mod N_SPACES on each grant.
  - Set that bit, entry_ack=1, entry_space=index.
- Entry when full: entry_reject=1, entry_ack=0, entry_space=0, no state change. The MODE 1 pointer is unchanged.
- Valid exit (exit_space < N_SPACES and that bit is occupied): clear the bit, exit_ack=1.
- Invalid exit (index ≥ N_SPACES or bay already free): exit_err=1, no state change.
- Simultaneous entry and exit in one cycle:
  - Both are processed.
  - The entry search uses pre-edge occupancy, so the bay being vacated is not grantable in that cycle.
  - If the lot is full, the entry is rejected and the exit still succeeds, leaving free_count=1.
  - Net free_count change is 0 when both succeed.
- free_count is updated on the same edge as occupancy: +1 on a valid exit, −1 on a grant. It never underflows or overflows.
- full and empty are derived from the next-state free_count and registered, so they stay consistent with free_count every cycle.
- Reset asserted mid-operation: all bays are released on that edge, and no ack or err for requests sampled in that cycle.

Test Plan:
- Reset, then entry_req high for 8 cycles (N_SPACES=8, MODE 0) -> entry_space 0,1,…,7 each with entry_ack. After the last grant: free_count=0, full=1, occupancy=8'hFF. A 9th cycle gives entry_reject=1.
- From full, exit_req with exit_space=3, then entry_req -> exit_ack, free_count=1. The next grant is entry_space=3, and full returns to 1.
- Full lot, entry_req and exit_req(5) in the same cycle -> entry_reject=1, exit_ack=1, occupancy=8'hDF, free_count=1. The following entry grants 5.
- exit_req on free bay 2, and (N_SPACES=6) exit_space=7 -> exit_err=1 each time, occupancy and free_count unchanged.
- MODE 1, N_SPACES=4: grant 0,1, release 0, entry -> grant 2 (not 0). Then grant 3, then the next entry wraps to grant 0.
- Reset asserted while occupancy=8'h5A with entry_req=1 -> next cycle occupancy=0, free_count=8, empty=1, no acks.
